sabr_mul_pipe_hs: RTL and testbench
===================================

Name: sabr_mul_pipe_hs

Overview:
- Parametrised, pipelined integer multiplier with valid/ready flow control.
- Per-transaction signed/unsigned operand mode and a sideband tag travel with each operand pair.
- Next-generation replacement for the fixed-width combinational unsigned multipliers in the SABR Monte-Carlo datapath (path-update and variance products).
- Sits between the RNG/Euler-step stages and the accumulator. It tolerates downstream stalls without losing or duplicating products.

Parameters:
- ID, 1, instance identifier; no functional effect.
- NUM_STAGE, 3, pipeline depth in register stages (>=1); equals latency in cycles when not stalled.
- din0_WIDTH, 49, operand A width.
- din1_WIDTH, 44, operand B width.
- dout_WIDTH, 93, result width.
- TAG_WIDTH, 8, sideband tag width (>=1).

Ports:
- clk  in  1  clock, rising edge.
- reset  in  1  synchronous active-high reset.
- in_valid  in  1  operand pair presented.
- in_ready  out  1  block accepts the pair this cycle.
- din0  in  din0_WIDTH  operand A.
- din1  in  din1_WIDTH  operand B.
- din0_signed  in  1  1 = treat din0 as two's complement.
- din1_signed  in  1  1 = treat din1 as two's complement.
- in_tag  in  TAG_WIDTH  sideband, returned unchanged with the product.
- out_valid  out  1  product present.
- out_ready  in  1  consumer accepts the product this cycle.
- dout  out  dout_WIDTH  product.
- out_tag  out  TAG_WIDTH  tag of the product on dout.

Behaviour:
- Interface: one clock `clk`; reset `reset` is synchronous and active-high.
- Reset: all stage valid bits, out_valid, dout, out_tag and internal data registers are 0. in_ready is 1 in the first cycle after reset deasserts. Reset mid-operation discards all in-flight products; none emerge afterwards.
- Transfers:
  - Input transfer occurs when in_valid && in_ready.
  - Output transfer occurs when out_valid && out_ready.
  - in_valid must hold its data stable until accepted. in_ready never depends combinationally on in_valid.
- Pipeline of NUM_STAGE stages, each with a valid bit v[k] (k = 0 .. NUM_STAGE-1).
  - Stage 0 captures din0, din1, the two sign flags and in_tag.
  - The product is formed from the stage-0 registers and registered into stage 1. Stages 2 .. NUM_STAGE-1 are pure delay.
  - Last stage drives dout, out_tag and out_valid = v[NUM_STAGE-1].
  - For NUM_STAGE = 1, dout is the combinational product of the stage-0 registers.
- Advance rule (bubble-collapsing):
  - The last stage may load when !v[last] or out_ready.
  - Stage k may load when !v[k] or stage k+1 loads.
  - in_ready = load enable of stage 0.
  - A stage that loads from an empty predecessor becomes invalid.
- Latency: an accepted pair appears on dout exactly NUM_STAGE cycles later when out_ready is held 1. Throughput is 1 per cycle.
- Arithmetic:
  - Each operand is extended by one bit: sign-extended if its flag is 1, zero-extended otherwise.
  - The product is the signed product at width din0_WIDTH + din1_WIDTH + 2.
  - dout = low dout_WIDTH bits of that product; if dout_WIDTH exceeds the full width, sign-extend.
  - With both flags 0, the result matches an unsigned multiply of the same widths.
- Stall: while out_valid && !out_ready, dout and out_tag hold stable. Internal bubbles still fill, so in_ready deasserts only when every stage is valid.
- Simultaneous events:
  - An input transfer and an output transfer in the same cycle on a full pipe are both legal. Occupancy is unchanged.
  - Reset has priority over any transfer.
- Ordering: products emerge strictly in acceptance order. No loss, no duplication.

Decomposition:
- Shared package sabr_arith_pkg:
  - function for operand extension (width, signed flag);
  - localparam for full product width (din0_WIDTH + din1_WIDTH + 2);
  - typedef for the tag.
- One natural sub-module, sabr_pipe_stage_hs: a single valid/data register slice with the load rule above, instantiated NUM_STAGE-1 times behind the multiply stage.

Test Plan:
- Unsigned, no stall, defaults: din0 = 2^48+3, din1 = 2^43+5, both flags 0, tag 0x11 -> after 3 cycles dout = 2^91 + 5*2^48 + 3*2^43 + 15, out_tag = 0x11.
- Signed: din0 = -7 (din0_signed = 1), din1 = 6 (din1_signed = 0), tag 0x22 -> dout = -42 sign-extended to 93 bits.
- Back-to-back: 20 random pairs, one per cycle, out_ready = 1 -> 20 correct products in order, one per cycle, in_ready constant 1.
- Backpressure: out_ready = 0 for 10 cycles while feeding -> exactly 3 pairs accepted, then in_ready = 0 and dout held stable. On release, the 3 products drain in order with no loss.
- Reset mid-flight: accept 2 pairs, assert reset for 1 cycle on the following cycle -> out_valid, dout and out_tag read 0. Neither product ever appears. in_ready = 1 after reset.
- Configuration NUM_STAGE=1, din0_WIDTH=14, din1_WIDTH=12, dout_WIDTH=26: din0 = 16383, din1 = 4095, unsigned -> dout = 67088385, one cycle after acceptance.

Source files
------------

// File: rtl/sabr_arith_pkg.sv
// Shared arithmetic helpers for the SABR multiplier datapath: operand
// extension, product-width arithmetic and the default sideband tag type.
package sabr_arith_pkg;

    localparam int unsigned DIN0_W_DEF = 32'd49;
    localparam int unsigned DIN1_W_DEF = 32'd44;
    localparam int unsigned TAG_W_DEF  = 32'd8;

    // Full signed product width for the default operand geometry.
    localparam int unsigned PROD_W_DEF = DIN0_W_DEF + DIN1_W_DEF + 32'd2;

    typedef logic [TAG_W_DEF-1:0] tag_t;

    // Width of an operand once it carries its extra extension bit.
    function automatic int unsigned ext_width(input int unsigned w);
        return w + 32'd1;
    endfunction

    // Exact signed product width of two extended operands.
    function automatic int unsigned prod_width(input int unsigned a_w, input int unsigned b_w);
        return ext_width(a_w) + ext_width(b_w);
    endfunction

    // Extension bit for an operand: copy of its MSB in signed mode, 0 otherwise.
    function automatic logic ext_bit(input logic msb, input logic is_signed);
        return msb & is_signed;
    endfunction

endpackage

// File: rtl/sabr_mul_pipe_hs_if.sv
// Valid/ready operand and product bus of the SABR pipelined multiplier.
interface sabr_mul_pipe_hs_if #(
    parameter int A_W = 49,
    parameter int B_W = 44,
    parameter int D_W = 93,
    parameter int T_W = 8
) ();
    logic           in_valid;
    logic           in_ready;
    logic [A_W-1:0] din0;
    logic [B_W-1:0] din1;
    logic           din0_signed;
    logic           din1_signed;
    logic [T_W-1:0] in_tag;
    logic           out_valid;
    logic           out_ready;
    logic [D_W-1:0] dout;
    logic [T_W-1:0] out_tag;

    // Multiplier side.
    modport slave (
        input  in_valid, din0, din1, din0_signed, din1_signed, in_tag, out_ready,
        output in_ready, out_valid, dout, out_tag
    );

    // Producer/consumer side.
    modport master (
        output in_valid, din0, din1, din0_signed, din1_signed, in_tag, out_ready,
        input  in_ready, out_valid, dout, out_tag
    );
endinterface

// File: rtl/sabr_pipe_stage_hs.sv
// One valid/data register slice of the multiplier delay chain. The caller
// supplies the load enable; data only moves when a valid item arrives, so an
// empty slot keeps its last contents and the output stays quiet.
module sabr_pipe_stage_hs #(
    parameter int DATA_W = 8
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              load_i,
    input  logic              valid_i,
    input  logic [DATA_W-1:0] data_i,
    output logic              valid_o,
    output logic [DATA_W-1:0] data_o
);
    logic              valid_q;
    logic [DATA_W-1:0] data_q;

    // Slice register: take the predecessor when allowed to load, else hold.
    always_ff @(posedge clk) begin
        if (reset) begin
            valid_q <= 1'b0;
            data_q  <= '0;
        end else if (load_i) begin
            valid_q <= valid_i;
            if (valid_i) begin
                data_q <= data_i;
            end
        end
    end

    assign valid_o = valid_q;
    assign data_o  = data_q;

endmodule

// File: rtl/sabr_mul_pipe_hs.sv
// Pipelined signed/unsigned integer multiplier with valid/ready flow control
// and a sideband tag. Stage 0 registers the operands, the product is formed
// from those registers, and NUM_STAGE-1 slices delay it to the output.
module sabr_mul_pipe_hs
    import sabr_arith_pkg::*;
#(
    parameter int ID         = 1,
    parameter int NUM_STAGE  = 3,
    parameter int din0_WIDTH = 49,
    parameter int din1_WIDTH = 44,
    parameter int dout_WIDTH = 93,
    parameter int TAG_WIDTH  = 8
) (
    input  logic                clk,
    input  logic                reset,
    sabr_mul_pipe_hs_if.slave   bus
);
    localparam int A_EXT_W = int'(ext_width(din0_WIDTH));
    localparam int B_EXT_W = int'(ext_width(din1_WIDTH));
    localparam int PROD_W  = int'(prod_width(din0_WIDTH, din1_WIDTH));
    localparam int DW      = dout_WIDTH + TAG_WIDTH;

    // Stage-0 operand registers and their next-state values.
    logic                  v0_q, v0_d;
    logic [din0_WIDTH-1:0] a_q, a_d;
    logic [din1_WIDTH-1:0] b_q, b_d;
    logic                  sa_q, sa_d;
    logic                  sb_q, sb_d;
    logic [TAG_WIDTH-1:0]  tag0_q, tag0_d;

    // Per-stage valid bits and load enables.
    logic [NUM_STAGE-1:0] v_s;
    logic [NUM_STAGE-1:0] ld_s;

    // Product datapath.
    logic signed [A_EXT_W-1:0]  a_ext_s;
    logic signed [B_EXT_W-1:0]  b_ext_s;
    logic signed [PROD_W-1:0]   a_full_s;
    logic signed [PROD_W-1:0]   b_full_s;
    logic signed [PROD_W-1:0]   prod_s;
    logic        [dout_WIDTH-1:0] res_s;

    // Stage data ({product, tag}); element 0 is the combinational product.
    logic [DW-1:0] sd_s [NUM_STAGE];

    // Load enables: a stage may load when it or any later stage is empty, or
    // when the consumer takes the head. This collapses bubbles so the pipe
    // only refuses input when every stage holds a product.
    always_comb begin
        ld_s = '0;
        for (int k = 0; k < NUM_STAGE; k++) begin
            ld_s[k] = bus.out_ready;
            for (int j = k; j < NUM_STAGE; j++) begin
                ld_s[k] = ld_s[k] | ~v_s[j];
            end
        end
    end

    // Stage-0 next state: capture operands on an input transfer, go empty
    // when loading with nothing presented, otherwise hold.
    always_comb begin
        v0_d   = v0_q;
        a_d    = a_q;
        b_d    = b_q;
        sa_d   = sa_q;
        sb_d   = sb_q;
        tag0_d = tag0_q;
        if (ld_s[0]) begin
            v0_d = bus.in_valid;
            if (bus.in_valid) begin
                a_d    = bus.din0;
                b_d    = bus.din1;
                sa_d   = bus.din0_signed;
                sb_d   = bus.din1_signed;
                tag0_d = bus.in_tag;
            end else begin
                a_d    = a_q;
                b_d    = b_q;
                sa_d   = sa_q;
                sb_d   = sb_q;
                tag0_d = tag0_q;
            end
        end else begin
            v0_d = v0_q;
        end
    end

    // Stage-0 register bank.
    always_ff @(posedge clk) begin
        if (reset) begin
            v0_q   <= 1'b0;
            a_q    <= '0;
            b_q    <= '0;
            sa_q   <= 1'b0;
            sb_q   <= 1'b0;
            tag0_q <= '0;
        end else begin
            v0_q   <= v0_d;
            a_q    <= a_d;
            b_q    <= b_d;
            sa_q   <= sa_d;
            sb_q   <= sb_d;
            tag0_q <= tag0_d;
        end
    end

    // One extra bit per operand makes every mode a plain signed multiply;
    // the product of the extended operands fits PROD_W exactly. The final
    // cast truncates or sign-extends to the output width.
    assign a_ext_s  = {ext_bit(a_q[din0_WIDTH-1], sa_q), a_q};
    assign b_ext_s  = {ext_bit(b_q[din1_WIDTH-1], sb_q), b_q};
    assign a_full_s = PROD_W'(a_ext_s);
    assign b_full_s = PROD_W'(b_ext_s);
    assign prod_s   = a_full_s * b_full_s;
    assign res_s    = dout_WIDTH'(prod_s);

    assign v_s[0]  = v0_q;
    assign sd_s[0] = {res_s, tag0_q};

    for (genvar k = 1; k < NUM_STAGE; k++) begin : g_stage
        sabr_pipe_stage_hs #(
            .DATA_W (DW)
        ) u_stage (
            .clk     (clk),
            .reset   (reset),
            .load_i  (ld_s[k]),
            .valid_i (v_s[k-1]),
            .data_i  (sd_s[k-1]),
            .valid_o (v_s[k]),
            .data_o  (sd_s[k])
        );
    end

    assign bus.in_ready  = ld_s[0];
    assign bus.out_valid = v_s[NUM_STAGE-1];
    assign bus.dout      = sd_s[NUM_STAGE-1][DW-1:TAG_WIDTH];
    assign bus.out_tag   = sd_s[NUM_STAGE-1][TAG_WIDTH-1:0];

endmodule

// File: tb/tb_sabr_mul_pipe_hs.sv
// Scoreboard bench for sabr_mul_pipe_hs: a default 3-stage instance and a
// 1-stage 14x12 instance. Accepted pairs push hand-computed products; output
// monitors pop and compare on every output transfer.
module tb_sabr_mul_pipe_hs;
    import sabr_arith_pkg::*;

    typedef struct {
        logic [92:0] d;
        tag_t        t;
        int          c;
        bit          lat;
    } exp_t;

    logic clk = 1'b0;
    logic reset = 1'b1;
    int   cyc = 0;
    int   chk_total = 0;
    int   chk_pass = 0;
    bit   lat_en = 1'b1;

    exp_t sb0[$];
    exp_t sb1[$];
    logic [92:0] exp_d0;
    tag_t        exp_t0;
    logic [92:0] exp_d1;
    tag_t        exp_t1;

    sabr_mul_pipe_hs_if #(.A_W(49), .B_W(44), .D_W(93), .T_W(8)) bus0 ();
    sabr_mul_pipe_hs_if #(.A_W(14), .B_W(12), .D_W(26), .T_W(8)) bus1 ();

    sabr_mul_pipe_hs u_dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus0)
    );

    sabr_mul_pipe_hs #(
        .ID(2), .NUM_STAGE(1), .din0_WIDTH(14), .din1_WIDTH(12), .dout_WIDTH(26), .TAG_WIDTH(8)
    ) u_dut1 (
        .clk   (clk),
        .reset (reset),
        .bus   (bus1)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        chk_total++;
        if (act === exp) chk_pass++;
        else $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    endtask

    // Monitor for the 3-stage instance: scoreboard pushes and pops.
    always @(negedge clk) begin
        exp_t e;
        if (!reset && bus0.out_valid && bus0.out_ready) begin
            if (sb0.size() == 0) begin
                chk_total++;
                $display("FAIL spurious0: got product %0h tag %0h with nothing expected", bus0.dout, bus0.out_tag);
            end else begin
                e = sb0.pop_front();
                check("dout0", 128'(bus0.dout), 128'(e.d));
                check("tag0", 128'(bus0.out_tag), 128'(e.t));
                if (e.lat) check("latency0", 128'(cyc - e.c), 128'(3));
            end
        end
        if (!reset && bus0.in_valid && bus0.in_ready)
            sb0.push_back('{exp_d0, exp_t0, cyc, lat_en});
    end

    // Monitor for the 1-stage instance.
    always @(negedge clk) begin
        exp_t e;
        if (!reset && bus1.out_valid && bus1.out_ready) begin
            if (sb1.size() == 0) begin
                chk_total++;
                $display("FAIL spurious1: got product %0h tag %0h with nothing expected", bus1.dout, bus1.out_tag);
            end else begin
                e = sb1.pop_front();
                check("dout1", 128'(bus1.dout), 128'(e.d));
                check("tag1", 128'(bus1.out_tag), 128'(e.t));
                if (e.lat) check("latency1", 128'(cyc - e.c), 128'(1));
            end
        end
        if (!reset && bus1.in_valid && bus1.in_ready)
            sb1.push_back('{exp_d1, exp_t1, cyc, 1'b1});
    end

    function automatic logic [48:0] pa(input int i);
        return 49'h0_1357_9BDF_0246 + 49'(i) * 49'h0_0000_1111_1111;
    endfunction

    function automatic logic [43:0] pb(input int i);
        return 44'h123_4567_89AB - 44'(i) * 44'h000_0010_0101;
    endfunction

    task automatic send0(input logic [48:0] a, input logic [43:0] b, input logic sa, input logic sb,
                         input tag_t tag, input logic [92:0] exp, output int waited);
        waited = 0;
        bus0.din0 = a; bus0.din1 = b; bus0.din0_signed = sa; bus0.din1_signed = sb;
        bus0.in_tag = tag; exp_d0 = exp; exp_t0 = tag; bus0.in_valid = 1'b1;
        forever begin
            @(negedge clk);
            if (bus0.in_ready) break;
            waited++;
            if (waited > 200) begin
                chk_total++;
                $display("FAIL send0_timeout: in_ready stayed 0 for %0d cycles", waited);
                break;
            end
        end
        @(posedge clk); #1;
        bus0.in_valid = 1'b0;
    endtask

    task automatic send1(input logic [13:0] a, input logic [11:0] b, input logic sa, input logic sb,
                         input tag_t tag, input logic [25:0] exp);
        int waited;
        waited = 0;
        bus1.din0 = a; bus1.din1 = b; bus1.din0_signed = sa; bus1.din1_signed = sb;
        bus1.in_tag = tag; exp_d1 = 93'(exp); exp_t1 = tag; bus1.in_valid = 1'b1;
        forever begin
            @(negedge clk);
            if (bus1.in_ready) break;
            waited++;
            if (waited > 200) begin
                chk_total++;
                $display("FAIL send1_timeout: in_ready stayed 0 for %0d cycles", waited);
                break;
            end
        end
        @(posedge clk); #1;
        bus1.in_valid = 1'b0;
    endtask

    task automatic drain(input bit which);
        int n;
        n = 0;
        while (((which == 1'b0) ? sb0.size() : sb1.size()) != 0 && n < 100) begin
            @(negedge clk);
            n++;
        end
        if (((which == 1'b0) ? sb0.size() : sb1.size()) != 0) begin
            chk_total++;
            $display("FAIL drain%0d_timeout: %0d products still outstanding", which,
                     (which == 1'b0) ? sb0.size() : sb1.size());
        end
        @(posedge clk); #1;
    endtask

    initial begin
        int   w;
        int   acc;
        int   idx;
        bit   have;
        bit   took;
        logic [92:0] held;
        logic [92:0] e;

        bus0.in_valid = 1'b0; bus0.out_ready = 1'b1; bus0.din0 = '0; bus0.din1 = '0;
        bus0.din0_signed = 1'b0; bus0.din1_signed = 1'b0; bus0.in_tag = '0;
        bus1.in_valid = 1'b0; bus1.out_ready = 1'b1; bus1.din0 = '0; bus1.din1 = '0;
        bus1.din0_signed = 1'b0; bus1.din1_signed = 1'b0; bus1.in_tag = '0;
        exp_d0 = '0; exp_t0 = '0; exp_d1 = '0; exp_t1 = '0;
        held = '0;

        repeat (3) @(posedge clk);
        #1 reset = 1'b0;

        // Reset state, first cycle after reset release.
        @(negedge clk);
        check("rst_out_valid0", 128'(bus0.out_valid), 128'(0));
        check("rst_dout0", 128'(bus0.dout), 128'(0));
        check("rst_out_tag0", 128'(bus0.out_tag), 128'(0));
        check("rst_in_ready0", 128'(bus0.in_ready), 128'(1));
        check("rst_out_valid1", 128'(bus1.out_valid), 128'(0));
        check("rst_dout1", 128'(bus1.dout), 128'(0));
        check("rst_in_ready1", 128'(bus1.in_ready), 128'(1));
        @(posedge clk); #1;

        // Directed vectors on the default instance.
        e = (93'd1 << 91) + (93'd5 << 48) + (93'd3 << 43) + 93'd15;
        send0(49'h1_0000_0000_0003, 44'h800_0000_0005, 1'b0, 1'b0, 8'h11, e, w);
        e = 93'd0 - 93'd42;
        send0(49'h1_FFFF_FFFF_FFF9, 44'h000_0000_0006, 1'b1, 1'b0, 8'h22, e, w);
        e = 93'd15;
        send0(49'h1_FFFF_FFFF_FFFD, 44'hFFF_FFFF_FFFB, 1'b1, 1'b1, 8'h23, e, w);
        e = 93'd1 << 91;
        send0(49'h1_0000_0000_0000, 44'h800_0000_0000, 1'b1, 1'b1, 8'h24, e, w);
        e = 93'd0 - (93'd1 << 49) - (93'd1 << 44) + 93'd1;
        send0(49'h1_FFFF_FFFF_FFFF, 44'hFFF_FFFF_FFFF, 1'b0, 1'b0, 8'h25, e, w);
        drain(1'b0);

        // Back-to-back: one pair per cycle, in_ready must never drop.
        for (int i = 0; i < 20; i++) begin
            e = 93'(pa(i)) * 93'(pb(i));
            send0(pa(i), pb(i), 1'b0, 1'b0, tag_t'(8'h40 + i), e, w);
            check("b2b_in_ready_wait", 128'(w), 128'(0));
        end
        drain(1'b0);

        // Backpressure: consumer stalls for 10 cycles while the producer feeds.
        lat_en = 1'b0;
        bus0.out_ready = 1'b0;
        idx = 100; acc = 0; have = 1'b0;
        bus0.din0 = pa(idx); bus0.din1 = pb(idx); bus0.din0_signed = 1'b0; bus0.din1_signed = 1'b0;
        bus0.in_tag = tag_t'(idx); exp_d0 = 93'(pa(idx)) * 93'(pb(idx)); exp_t0 = tag_t'(idx);
        bus0.in_valid = 1'b1;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            took = bus0.in_ready;
            if (took) acc++;
            if (have) check("bp_dout_hold", 128'(bus0.dout), 128'(held));
            else if (bus0.out_valid) begin
                held = bus0.dout;
                have = 1'b1;
            end
            @(posedge clk); #1;
            if (took) begin
                idx++;
                bus0.din0 = pa(idx); bus0.din1 = pb(idx); bus0.in_tag = tag_t'(idx);
                exp_d0 = 93'(pa(idx)) * 93'(pb(idx)); exp_t0 = tag_t'(idx);
            end
        end
        @(negedge clk);
        check("bp_accepted", 128'(acc), 128'(3));
        check("bp_in_ready", 128'(bus0.in_ready), 128'(0));
        check("bp_out_valid", 128'(bus0.out_valid), 128'(1));
        check("bp_dout_first", 128'(held), 128'(93'(pa(100)) * 93'(pb(100))));
        @(posedge clk); #1;
        bus0.in_valid = 1'b0;
        bus0.out_ready = 1'b1;
        drain(1'b0);
        lat_en = 1'b1;

        // Single-stage 14x12 configuration.
        send1(14'd16383, 12'd4095, 1'b0, 1'b0, 8'h33, 26'd67088385);
        send1(14'h3FFF, 12'hFFF, 1'b1, 1'b1, 8'h34, 26'd1);
        send1(14'h3FFF, 12'hFFF, 1'b1, 1'b0, 8'h35, 26'd67104769);
        drain(1'b1);

        // Reset mid-flight: two products in the pipe are discarded.
        send0(pa(200), pb(200), 1'b0, 1'b0, 8'h51, 93'(pa(200)) * 93'(pb(200)), w);
        send0(pa(201), pb(201), 1'b0, 1'b0, 8'h52, 93'(pa(201)) * 93'(pb(201)), w);
        reset = 1'b1;
        sb0.delete();
        @(posedge clk); #1;
        reset = 1'b0;
        @(negedge clk);
        check("mid_rst_out_valid", 128'(bus0.out_valid), 128'(0));
        check("mid_rst_dout", 128'(bus0.dout), 128'(0));
        check("mid_rst_out_tag", 128'(bus0.out_tag), 128'(0));
        check("mid_rst_in_ready", 128'(bus0.in_ready), 128'(1));
        repeat (10) @(negedge clk);

        check("final_sb0_empty", 128'(sb0.size()), 128'(0));
        check("final_sb1_empty", 128'(sb1.size()), 128'(0));

        $display("%0d/%0d checks passed", chk_pass, chk_total);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: bench did not finish");
        $fatal(1);
    end

endmodule
